// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: stage state
// encodings, per-stage default widths and control-bit positions.
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_FULL  = ST_FULL,
      S_SKID  = ST_SKID
   } stage_state_t;

   // Default payload/control widths for each latch of the 5-stage core
   localparam int IFID_DATA_W  = 64;
   localparam int IFID_CTRL_W  = 8;
   localparam int IDEX_DATA_W  = 133;
   localparam int IDEX_CTRL_W  = 8;
   localparam int EXMEM_DATA_W = 72;
   localparam int EXMEM_CTRL_W = 8;
   localparam int MEMWB_DATA_W = 69;
   localparam int MEMWB_CTRL_W = 8;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMTOREG = 3;

   function automatic logic [1:0] occ_of(input stage_state_t s);
      case (s)
         S_FULL:  return 2'd1;
         S_SKID:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline holding slot: valid + control + payload, with load and clear.
// Clear beats load; clear zeroes valid and control only.
module pipe_stage_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (i_clear) begin
         // NOTE: payload keeps its stale value on clear; valid and the zeroed
         // control field are what stop a bubble from having any effect.
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ctrl  <= i_ctrl;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline-stage register with flush and bubble zeroing.
// Define PIPE_STAGE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   stage_state_t      r_state;
   stage_state_t      w_state_nxt;
   logic              w_accept;
   logic              w_drain;
   logic              w_main_load;
   logic              w_main_clear;
   logic              w_main_valid;
   logic [DATA_W-1:0] w_main_data_d;
   logic [DATA_W-1:0] w_main_data;
   logic [CTRL_W-1:0] w_main_ctrl_d;
   logic [CTRL_W-1:0] w_main_ctrl;

`ifdef PIPE_STAGE_SKID_EN
   logic              w_skid_load;
   logic              w_skid_clear;
   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_data;
   logic [CTRL_W-1:0] w_skid_ctrl;

   // Ready comes straight from a flop, breaking the out_ready timing path.
   assign in_ready  = ~w_skid_valid;
   assign occupancy = occ_of(r_state);
`else
   assign in_ready  = out_ready | ~w_main_valid;
   assign occupancy = {1'b0, r_state == S_FULL};
`endif

   assign w_accept = in_valid & in_ready;
   assign w_drain  = w_main_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state flops use non-blocking assignment so every register in
      // the design samples the pre-edge values, independent of block order.
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can infer a latch.
      w_state_nxt   = r_state;
      w_main_load   = 1'b0;
      w_main_clear  = 1'b0;
      w_main_data_d = in_data;
      w_main_ctrl_d = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_load   = 1'b0;
      w_skid_clear  = 1'b0;
`endif
      if (flush) begin
         w_state_nxt  = S_EMPTY;
         w_main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         w_skid_clear = 1'b1;
`endif
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_main_load = 1'b1;
                  w_state_nxt = S_FULL;
               end
            end
            S_FULL: begin
               if (w_accept && w_drain) begin
                  w_main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               end else if (w_accept) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = S_SKID;
`endif
               end else if (w_drain) begin
                  w_main_clear = 1'b1;
                  w_state_nxt  = S_EMPTY;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            S_SKID: begin
               // Skid beat is older than anything upstream, so it refills main.
               if (w_drain) begin
                  w_main_load   = 1'b1;
                  w_main_data_d = w_skid_data;
                  w_main_ctrl_d = w_skid_ctrl;
                  w_skid_clear  = 1'b1;
                  w_state_nxt   = S_FULL;
               end
            end
`endif
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_data  (w_main_data_d),
      .i_ctrl  (w_main_ctrl_d),
      .o_valid (w_main_valid),
      .o_data  (w_main_data),
      .o_ctrl  (w_main_ctrl)
   );

`ifdef PIPE_STAGE_SKID_EN
   pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (in_data),
      .i_ctrl  (in_ctrl),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data),
      .o_ctrl  (w_skid_ctrl)
   );
`endif

   assign out_valid = w_main_valid;
   assign out_data  = w_main_data;
   assign out_ctrl  = w_main_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, scoreboard queue of
// held beats, and hand sequences for reset, back-pressure, flush and bubble.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID_BUILD = 1'b1;
`else
   localparam bit SKID_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_ctrl;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_ctrl;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  ctrl;
   } beat_t;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic [7:0]  c;
      logic        ordy;
      logic        fl;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [1:0]  exp_occ;
   } vec_t;

   beat_t sb_q[$];
   vec_t  vecs[10];

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Compare against the reference queue of held beats, then apply the edge.
   task automatic advance();
      int    n;
      logic  m_ready;
      logic  acc;
      logic  drn;
      beat_t b;
      n       = sb_q.size();
      m_ready = SKID_BUILD ? (n < 2) : (out_ready || n == 0);
      check("sb_in_ready", in_ready, m_ready);
      check("sb_out_valid", out_valid, n != 0);
      check("sb_occupancy", occupancy, n);
      if (n != 0) begin
         check("sb_out_data", out_data, sb_q[0].data);
         check("sb_out_ctrl", out_ctrl, sb_q[0].ctrl);
      end else begin
         check("sb_bubble_ctrl", out_ctrl, 0);
      end
      if (flush) begin
         sb_q.delete();
      end else begin
         acc = in_valid && m_ready;
         drn = (n != 0) && out_ready;
         if (drn) void'(sb_q.pop_front());
         if (acc) begin
            b.data = in_data;
            b.ctrl = in_ctrl;
            sb_q.push_back(b);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl);
      drive(v, d, c, ordy, fl);
      settle();
      advance();
   endtask

   initial begin
      for (int i = 0; i < 10; i++) begin
         vecs[i].iv        = (i < 8);
         vecs[i].d         = 32'(i + 1);
         vecs[i].c         = 8'(i + 1);
         vecs[i].ordy      = 1'b1;
         vecs[i].fl        = 1'b0;
         vecs[i].exp_valid = (i >= 1 && i <= 8);
         vecs[i].exp_data  = 32'(i);
         vecs[i].exp_occ   = (i >= 1 && i <= 8) ? 2'd1 : 2'd0;
      end

      // Reset from time zero
      rst = 1'b1;
      drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_occupancy", occupancy, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Streaming 0x1..0x8 back-to-back
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
         settle();
         check("tbl_out_valid", out_valid, vecs[i].exp_valid);
         check("tbl_occupancy", occupancy, vecs[i].exp_occ);
         if (vecs[i].exp_valid) check("tbl_out_data", out_data, vecs[i].exp_data);
         advance();
      end

      // Back-pressure: 0xA,0xB,0xC with out_ready dropped while 0xA is held
      cycle(1'b1, 32'hA, 8'h1A, 1'b1, 1'b0);
      drive(1'b1, 32'hB, 8'h1B, 1'b0, 1'b0);
      settle();
      check("bp_hold_data", out_data, 32'hA);
      if (!SKID_BUILD) check("bp_noskid_in_ready", in_ready, 0);
      advance();
      if (SKID_BUILD) begin
         drive(1'b1, 32'hC, 8'h1C, 1'b0, 1'b0);
         settle();
         check("bp_skid_occupancy", occupancy, 2);
         check("bp_skid_in_ready", in_ready, 0);
         check("bp_skid_hold_data", out_data, 32'hA);
         advance();
         cycle(1'b1, 32'hC, 8'h1C, 1'b1, 1'b0);
         cycle(1'b1, 32'hC, 8'h1C, 1'b1, 1'b0);
         drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
         settle();
         check("bp_skid_last_data", out_data, 32'hC);
         advance();
      end else begin
         drive(1'b1, 32'hB, 8'h1B, 1'b0, 1'b0);
         settle();
         check("bp_noskid_stable", out_data, 32'hA);
         advance();
         cycle(1'b1, 32'hB, 8'h1B, 1'b1, 1'b0);
         drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
         settle();
         check("bp_noskid_last_data", out_data, 32'hB);
         advance();
      end
      cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      check("bp_drained_occ", occupancy, 0);

      // Flush with a simultaneous offer
      cycle(1'b1, 32'h1234, 8'hFF, 1'b1, 1'b0);
      cycle(1'b1, 32'hDEAD, 8'h77, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      settle();
      check("flush_out_valid", out_valid, 0);
      check("flush_out_ctrl", out_ctrl, 0);
      check("flush_occupancy", occupancy, 0);
      advance();
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

      // Flush while stalled with a second beat offered (fills skid if present)
      cycle(1'b1, 32'h51, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 32'h52, 8'h22, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

      // Bubble after a lone beat drains
      cycle(1'b1, 32'h42, 8'h0F, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      settle();
      check("bubble_held_ctrl", out_ctrl, 8'h0F);
      advance();
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      settle();
      check("bubble_out_valid", out_valid, 0);
      check("bubble_out_ctrl", out_ctrl, 0);
      advance();

      // Asynchronous reset in the middle of a held beat
      cycle(1'b1, 32'h99, 8'h3C, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_ctrl", out_ctrl, 0);
      check("arst_occupancy", occupancy, 0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      cycle(1'b1, 32'h77, 8'h05, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      settle();
      check("arst_first_beat", out_data, 32'h77);
      advance();
      cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Each instance carries a data payload plus a control field that is forced to zero whenever the stage holds a bubble. It sits between any two adjacent stages of the 5-stage core and gives stall back-pressure and hazard-flush support without per-stage hand-written logic.

## Interface
Parameters:
- DATA_W, 32, payload width (ALU result, store data, rd, load/store type, ...).
- CTRL_W, 8, control-bit width (regwrite, memread, memwrite, memtoreg, ...); zeroed on bubble or flush.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream offers a beat.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- flush  in  1  synchronous kill of every held and offered beat.
- out_valid  out  1  stage presents a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; 0 whenever out_valid=0.
- occupancy  out  2  number of held beats (0..2).

## Operation
- Accept when in_valid & in_ready. Drain when out_valid & out_ready.
- Storage is a main register (drives outputs) plus, when configured, a skid register.
- States: EMPTY (occ 0), FULL (main valid, occ 1), SKID (main and skid valid, occ 2; skid build only).
- EMPTY: an accept moves to FULL; the beat loads into main.
- FULL with accept and drain: main reloads with the new beat; stays FULL.
- FULL with drain only: goes to EMPTY and main.ctrl clears to 0.
- FULL with accept only: without skid this cannot happen, because in_ready=0. With skid, the beat goes to skid; state becomes SKID.
- SKID with drain: skid moves to main; goes to FULL. No accept is possible, because in_ready=0.
- Flush has priority over every other event. The next edge moves to EMPTY, clears both valid bits and zeroes both ctrl registers. A beat offered in the flush cycle is discarded. Data registers may keep stale values.
- Reset drives all valid bits, ctrl and data registers, and occupancy to 0, so out_valid=0, out_data=0 and out_ctrl=0. in_ready=1 while rst is deasserted and the stage is empty.
- The block does no arithmetic. Payload passes bit-exact, with no width conversion.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat per cycle under continuous out_ready=1, in both builds.
- in_ready without skid = out_ready | ~out_valid (combinational path from out_ready).
- in_ready with skid = ~skid_valid (registered; no combinational out_ready→in_ready path).
- Once out_valid is asserted, out_data and out_ctrl hold stable until drain or flush.
- Reset asserted mid-transfer clears the stage immediately and asynchronously. The first accept is possible on the first edge after release.

## Configuration
- PIPE_STAGE_SKID_EN defined: the skid register and the SKID state are compiled in. in_ready is registered, occupancy ranges 0..2, and one extra beat is absorbed after out_ready falls.
- PIPE_STAGE_SKID_EN undefined: main register only. in_ready is combinational, and occupancy never exceeds 1 (bit 1 tied to 0).

## Structure
- Shared package pipe_pkg holds:
  - localparam encodings for EMPTY/FULL/SKID;
  - default DATA_W/CTRL_W per stage (IFID, IDEX, EXMEM, MEMWB);
  - the CTRL bit-index constants (REGWRITE, MEMREAD, MEMWRITE, MEMTOREG).
- One natural sub-module: pipe_stage_slot, a single valid+ctrl+data register with load and clear. It is instantiated once for main and once for skid under the macro.

## Test plan
- Reset then idle: assert rst mid-cycle → out_valid=0, out_ctrl=0, out_data=0, occupancy=0 asynchronously. After release, in_ready=1.
- Streaming: in_valid=1 with data 0x1..0x8, out_ready=1 → out_data 0x1..0x8 appears one cycle later, back-to-back, with no gaps.
- Back-pressure (skid build): stream 0xA,0xB,0xC and drop out_ready while 0xA is held.
  - Required: 0xB is absorbed, occupancy=2, in_ready=0.
  - Raise out_ready: 0xA, 0xB, 0xC emerge in order, with no loss or duplication.
- Back-pressure (no skid): out_ready=0 with out_valid=1 → in_ready=0 in the same cycle, and out_data holds stable.
- Flush with simultaneous accept: held beat ctrl=0xFF, in_valid=1 and flush=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, and the offered beat never appears.
- Bubble: single beat with ctrl=0x0F drained, no new input → next cycle out_valid=0 and out_ctrl=0x00.
